// File: rtl/ex_hazard_ctrl_if.sv
// Bundle of the ID/EX/MEM hazard-relevant pipeline signals and the hazard
// controller's decisions. The slave modport is the controller's view; the
// master modport is the pipeline's view.
// Optional: HAZARD_PERF_EN adds the stall_count/flush_count event counters.
interface ex_hazard_ctrl_if;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        uses_rt_id;
  logic [4:0]  towrite_ex;
  logic        regwrite_ex;
  logic        memtoreg_ex;
  logic [4:0]  towrite_mem;
  logic        regwrite_mem;
  logic        branch_ex;
  logic        valid;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        stall_if;
  logic        stall_id;
  logic        bubble_ex;
  logic        flush_if;
  logic        init_active;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif

  modport master (
    output rs_id, rt_id, uses_rt_id, towrite_ex, regwrite_ex, memtoreg_ex,
           towrite_mem, regwrite_mem, branch_ex, valid,
`ifdef HAZARD_PERF_EN
    input  stall_count, flush_count,
`endif
    input  fwd_a, fwd_b, stall_if, stall_id, bubble_ex, flush_if, init_active
  );

  modport slave (
    input  rs_id, rt_id, uses_rt_id, towrite_ex, regwrite_ex, memtoreg_ex,
           towrite_mem, regwrite_mem, branch_ex, valid,
`ifdef HAZARD_PERF_EN
    output stall_count, flush_count,
`endif
    output fwd_a, fwd_b, stall_if, stall_id, bubble_ex, flush_if, init_active
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard sequencer: operand forwarding selects, load-use bubble,
// post-branch IF/ID flush and post-reset warm-up suppression.
// Optional: HAZARD_PERF_EN adds saturating stall/flush event counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// INIT     | warm-up after reset; forwarding and hazard detection off
// RUN      | normal operation; forwarding, load-use and branch checks
// LW_STALL | one-cycle hold after a load-use bubble; load now in MEM
// FLUSH    | IF/ID squashed after a taken branch; everything else ignored
module ex_hazard_ctrl #(
  parameter int INIT_CYCLES  = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  ex_hazard_ctrl_if.slave hif
);

  localparam int MAXC = (INIT_CYCLES > FLUSH_CYCLES) ? INIT_CYCLES : FLUSH_CYCLES;
  localparam int CW   = (MAXC <= 2) ? 1 : $clog2(MAXC);
  // INIT_CYCLES=0 behaves like a single warm-up cycle (RUN on first clock).
  localparam logic [CW-1:0] INIT_LOAD  = CW'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
  // Counter holds the number of FLUSH cycles still to spend, trigger excluded.
  localparam logic [CW-1:0] FLUSH_LOAD = CW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 1 : 0);
  localparam bit FLUSH_STAY = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {INIT, RUN, LW_STALL, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    fwd_a_q, fwd_b_q, fwd_a_nxt, fwd_b_nxt;
  logic [1:0]    fwd_a_calc, fwd_b_calc;
  logic          load_use, taken_evt;
  logic          stall_c, bubble_c, flush_c;

  // Operand source selection for the instruction currently in ID.
  always_comb begin
    fwd_a_calc = 2'b00;
    fwd_b_calc = 2'b00;
    if (hif.regwrite_ex && hif.towrite_ex != 5'd0 && hif.towrite_ex == hif.rs_id)
      fwd_a_calc = 2'b01;
    else if (hif.regwrite_mem && hif.towrite_mem != 5'd0 && hif.towrite_mem == hif.rs_id)
      fwd_a_calc = 2'b10;
    if (hif.uses_rt_id) begin
      if (hif.regwrite_ex && hif.towrite_ex != 5'd0 && hif.towrite_ex == hif.rt_id)
        fwd_b_calc = 2'b01;
      else if (hif.regwrite_mem && hif.towrite_mem != 5'd0 && hif.towrite_mem == hif.rt_id)
        fwd_b_calc = 2'b10;
    end
  end

  // Raw hazard conditions; the FSM decides whether they act this cycle.
  assign load_use = hif.memtoreg_ex && hif.regwrite_ex && (hif.towrite_ex != 5'd0) &&
                    ((hif.towrite_ex == hif.rs_id) ||
                     (hif.uses_rt_id && (hif.towrite_ex == hif.rt_id)));
  assign taken_evt = hif.branch_ex && hif.valid && (state == RUN || state == LW_STALL);

  // State, counter and registered forwarding selects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= INIT;
      cnt     <= INIT_LOAD;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      fwd_a_q <= fwd_a_nxt;
      fwd_b_q <= fwd_b_nxt;
    end
  end

  // Next-state and Mealy hazard outputs; a taken branch overrides load-use.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fwd_a_nxt = fwd_a_q;
    fwd_b_nxt = fwd_b_q;
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    flush_c   = 1'b0;
    case (state)
      INIT: begin
        fwd_a_nxt = 2'b00;
        fwd_b_nxt = 2'b00;
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - CW'(1);
      end
      RUN, LW_STALL: begin
        if (taken_evt) begin
          flush_c   = 1'b1;
          bubble_c  = 1'b1;
          fwd_a_nxt = 2'b00;
          fwd_b_nxt = 2'b00;
          cnt_nxt   = FLUSH_LOAD;
          state_nxt = FLUSH_STAY ? FLUSH : RUN;
        end else if (state == RUN && load_use) begin
          // Selects hold; they are re-evaluated once the load reaches MEM.
          stall_c   = 1'b1;
          bubble_c  = 1'b1;
          state_nxt = LW_STALL;
        end else begin
          fwd_a_nxt = fwd_a_calc;
          fwd_b_nxt = fwd_b_calc;
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        flush_c   = 1'b1;
        bubble_c  = 1'b1;
        fwd_a_nxt = 2'b00;
        fwd_b_nxt = 2'b00;
        if (cnt <= CW'(1)) state_nxt = RUN;
        else               cnt_nxt   = cnt - CW'(1);
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = INIT_LOAD;
      end
    endcase
  end

  assign hif.fwd_a       = fwd_a_q;
  assign hif.fwd_b       = fwd_b_q;
  assign hif.stall_if    = stall_c;
  assign hif.stall_id    = stall_c;
  assign hif.bubble_ex   = bubble_c;
  assign hif.flush_if    = flush_c;
  assign hif.init_active = (state == INIT);

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count_q, flush_count_q;

  // Saturating event counters for load-use stalls and taken branches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
    end else begin
      if (stall_c && stall_count_q != 16'hFFFF)   stall_count_q <= stall_count_q + 16'd1;
      if (taken_evt && flush_count_q != 16'hFFFF) flush_count_q <= flush_count_q + 16'd1;
    end
  end

  assign hif.stall_count = stall_count_q;
  assign hif.flush_count = flush_count_q;
`endif

endmodule
